// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: encode modes, fixed control/guard symbols and the TERC4 table.
// Every symbol is stored as {bit9..bit0}; bit 0 goes on the wire first.
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_VIDEO      = 3'd0,
        MODE_CONTROL    = 3'd1,
        MODE_TERC4      = 3'd2,
        MODE_GUARD_VID  = 3'd3,
        MODE_GUARD_DATA = 3'd4
    } tmds_mode_e;

    typedef logic [9:0] tmds_sym_t;

    localparam tmds_sym_t CTRL_CODE [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam tmds_sym_t GUARD_A = 10'b1011001100;
    localparam tmds_sym_t GUARD_B = 10'b0100110011;

    localparam tmds_sym_t TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    // Unused encodings 5-7 fold onto CONTROL so the link always carries a legal symbol.
    function automatic tmds_mode_e decode_mode(input logic [2:0] raw);
        return (raw > 3'd4) ? MODE_CONTROL : tmds_mode_e'(raw);
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/tmds_multi_encoder_if.sv
// Encoder bus: shared mode plus per-channel data/control/aux in, symbols and valid out.
// The master drives pixel-side inputs; the slave (an encoder) returns symbols.
interface tmds_multi_encoder_if #(
    parameter int NUM_CH = 3
);
    logic [2:0]           mode;
    logic [NUM_CH*8-1:0]  data;
    logic [NUM_CH*2-1:0]  ctrl;
    logic [NUM_CH*4-1:0]  aux;
    logic [NUM_CH*10-1:0] tmds;
    logic                 valid;

    modport master (output mode, data, ctrl, aux, input tmds, valid);
    modport slave  (input mode, data, ctrl, aux, output tmds, valid);
endinterface

// File: rtl/tmds_lane.sv
// One TMDS channel: stage 1 registers inputs with q_m and its ones count,
// stage 2 picks the output symbol and keeps this lane's running disparity.
module tmds_lane
    import tmds_pkg::*;
#(
    parameter int CH      = 0,
    parameter int TALLY_W = 5
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    tmds_multi_encoder_if.slave bus
);

    localparam logic [TALLY_W-1:0] TALLY_TWO = TALLY_W'(2);

    tmds_mode_e         mode_q, mode_d;
    logic [8:0]         qm_q, qm_d;
    logic [3:0]         n1_q, n1_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [3:0]         aux_q, aux_d;
    logic               valid1_q, valid1_d;
    logic               valid_q, valid_d;
    tmds_sym_t          tmds_q, tmds_d;
    logic [TALLY_W-1:0] tally_q, tally_d;

    logic [7:0]         din;
    logic [3:0]         din_ones;
    logic               use_xnor;
    logic [TALLY_W-1:0] n1_t, n0_t;
    logic               tally_pos, tally_neg;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        din      = bus.data[7:0];
        din_ones = ones8(din);
        use_xnor = (din_ones > 4'd4) || ((din_ones == 4'd4) && !din[0]);
        qm_d     = '0;
        qm_d[0]  = din[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ din[i]) : (qm_d[i-1] ^ din[i]);
        end
        qm_d[8]  = ~use_xnor;
        n1_d     = ones8(qm_d[7:0]);
        mode_d   = decode_mode(bus.mode);
        ctrl_d   = bus.ctrl[1:0];
        aux_d    = bus.aux[3:0];
        valid1_d = 1'b1;
    end

    always_comb begin
        n1_t      = TALLY_W'(n1_q);
        n0_t      = TALLY_W'(4'd8 - n1_q);
        tally_neg = tally_q[TALLY_W-1];
        tally_pos = !tally_neg && (tally_q != '0);
        tally_d   = '0;
        tmds_d    = CTRL_CODE[ctrl_q];
        valid_d   = valid1_q;
        case (mode_q)
            MODE_VIDEO: begin
                if ((tally_q == '0) || (n1_q == 4'd4)) begin
                    tmds_d  = qm_q[8] ? {2'b01, qm_q[7:0]} : {2'b10, ~qm_q[7:0]};
                    tally_d = qm_q[8] ? (tally_q + n1_t - n0_t) : (tally_q + n0_t - n1_t);
                end else if ((tally_pos && (n1_q > 4'd4)) || (tally_neg && (n1_q < 4'd4))) begin
                    tmds_d  = {1'b1, qm_q[8], ~qm_q[7:0]};
                    tally_d = tally_q + (qm_q[8] ? TALLY_TWO : '0) + n0_t - n1_t;
                end else begin
                    tmds_d  = {1'b0, qm_q[8], qm_q[7:0]};
                    tally_d = tally_q - (qm_q[8] ? '0 : TALLY_TWO) + n1_t - n0_t;
                end
            end
            MODE_TERC4:      tmds_d = TERC4_CODE[aux_q];
            MODE_GUARD_VID:  tmds_d = (CH == 1) ? GUARD_B : GUARD_A;
            MODE_GUARD_DATA: tmds_d = ((CH == 1) || (CH == 2)) ? GUARD_B
                                                                : TERC4_CODE[{2'b11, ctrl_q}];
            default:         tmds_d = CTRL_CODE[ctrl_q];
        endcase
    end

    // NOTE: state updates are non-blocking so every flop samples pre-edge values.
    // Reset parks the pipeline in CONTROL with a zero tally, so nothing survives an abort.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_q   <= MODE_CONTROL;
            qm_q     <= '0;
            n1_q     <= '0;
            ctrl_q   <= '0;
            aux_q    <= '0;
            valid1_q <= 1'b0;
            valid_q  <= 1'b0;
            tmds_q   <= '0;
            tally_q  <= '0;
        end else begin
            mode_q   <= mode_d;
            qm_q     <= qm_d;
            n1_q     <= n1_d;
            ctrl_q   <= ctrl_d;
            aux_q    <= aux_d;
            valid1_q <= valid1_d;
            valid_q  <= valid_d;
            tmds_q   <= tmds_d;
            tally_q  <= tally_d;
        end
    end

    assign bus.tmds  = tmds_q;
    assign bus.valid = valid_q;

endmodule

// File: rtl/tmds_multi_encoder.sv
// NUM_CH independent TMDS encoders sharing one mode, each a two-stage tmds_lane.
// Channel k uses bits [8k+7:8k] of data_in and emits tmds_out[10k+9:10k].
module tmds_multi_encoder #(
    parameter int NUM_CH  = 3,
    parameter int TALLY_W = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [2:0]           mode_in,
    input  logic [NUM_CH*8-1:0]  data_in,
    input  logic [NUM_CH*2-1:0]  ctrl_in,
    input  logic [NUM_CH*4-1:0]  aux_in,
    output logic [NUM_CH*10-1:0] tmds_out,
    output logic                 valid_out
);

    logic [NUM_CH-1:0] lane_valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        tmds_multi_encoder_if #(.NUM_CH(1)) lane_bus ();

        assign lane_bus.mode = mode_in;
        assign lane_bus.data = data_in[8*k +: 8];
        assign lane_bus.ctrl = ctrl_in[2*k +: 2];
        assign lane_bus.aux  = aux_in[4*k +: 4];

        tmds_lane #(
            .CH      (k),
            .TALLY_W (TALLY_W)
        ) u_lane (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .bus      (lane_bus)
        );

        assign tmds_out[10*k +: 10] = lane_bus.tmds;
        assign lane_valid[k]        = lane_bus.valid;
    end

    // All lanes share reset and clock, so their valid flags move together.
    assign valid_out = &lane_valid;

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Bench for tmds_multi_encoder with four channels: hand-computed vector table,
// mode-switching and random VIDEO streams against a behavioural model, and async reset aborts.
module tb_tmds_multi_encoder;

    localparam int NUM_CH  = 4;
    localparam int TALLY_W = 5;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] GA  = 10'b1011001100;
    localparam logic [9:0] GB  = 10'b0100110011;
    localparam logic [9:0] Z0  = 10'b0100000000;
    localparam logic [9:0] Z1  = 10'b1111111111;

    localparam logic [9:0] CTRL_TB [4] = '{C00, C01, C10, C11};
    localparam logic [9:0] TERC4_TB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] data;
        logic [7:0]  ctrl;
        logic [15:0] aux;
        logic [39:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    tmds_multi_encoder_if #(.NUM_CH(NUM_CH)) dut_if ();

    tmds_multi_encoder #(
        .NUM_CH  (NUM_CH),
        .TALLY_W (TALLY_W)
    ) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .mode_in   (dut_if.mode),
        .data_in   (dut_if.data),
        .ctrl_in   (dut_if.ctrl),
        .aux_in    (dut_if.aux),
        .tmds_out  (dut_if.tmds),
        .valid_out (dut_if.valid)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    vec_t        vecs [18];
    logic [39:0] pipe_exp  [2];
    logic [2:0]  pipe_mode [2];
    bit          pipe_v    [2];
    string       pipe_tag  [2];
    int          tally_m [NUM_CH];
    int          disp    [NUM_CH];
    int          max_disp = 0;
    int          steps_since = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int wrap_t(input int t);
        int m;
        m = ((t % (1 << TALLY_W)) + (1 << TALLY_W)) % (1 << TALLY_W);
        return (m >= (1 << (TALLY_W - 1))) ? m - (1 << TALLY_W) : m;
    endfunction

    function automatic logic [9:0] enc_video(input logic [7:0] d, input int t_in, output int t_out);
        logic [7:0] qm;
        logic       q8, xn;
        int         ones, n1, n0;
        logic [9:0] sym;
        ones  = $countones(d);
        xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        q8 = ~xn;
        n1 = $countones(qm);
        n0 = 8 - n1;
        if (t_in == 0 || n1 == n0) begin
            sym   = q8 ? {1'b0, 1'b1, qm} : {1'b1, 1'b0, ~qm};
            t_out = q8 ? t_in + n1 - n0 : t_in + n0 - n1;
        end else if ((t_in > 0 && n1 > n0) || (t_in < 0 && n0 > n1)) begin
            sym   = {1'b1, q8, ~qm};
            t_out = t_in + (q8 ? 2 : 0) + n0 - n1;
        end else begin
            sym   = {1'b0, q8, qm};
            t_out = t_in - (q8 ? 0 : 2) + n1 - n0;
        end
        t_out = wrap_t(t_out);
        return sym;
    endfunction

    function automatic logic [9:0] model_sym(input logic [2:0] m, input int ch, input logic [7:0] d,
                                             input logic [1:0] c, input logic [3:0] a,
                                             input int t_in, output int t_out);
        logic [9:0] sym;
        t_out = 0;
        case (m)
            3'd0:    sym = enc_video(d, t_in, t_out);
            3'd2:    sym = TERC4_TB[a];
            3'd3:    sym = (ch == 1) ? GB : GA;
            3'd4:    sym = (ch == 1 || ch == 2) ? GB : TERC4_TB[{2'b11, c}];
            default: sym = CTRL_TB[c];
        endcase
        return sym;
    endfunction

    // Each call: check the output owed by the inputs of two calls ago, then apply new inputs.
    task automatic step(input logic [2:0] m, input logic [31:0] d, input logic [7:0] c,
                        input logic [15:0] a, input bit use_hand, input logic [39:0] hand,
                        input string tag);
        logic [39:0] exp_all;
        logic [9:0]  act;
        int          t_new;
        @(negedge clk);
        steps_since++;
        check("valid", 64'(dut_if.valid), 64'(steps_since >= 2));
        if (pipe_v[1]) begin
            for (int k = 0; k < NUM_CH; k++) begin
                act = dut_if.tmds[10*k +: 10];
                check($sformatf("%s lane%0d", pipe_tag[1], k), 64'(act), 64'(pipe_exp[1][10*k +: 10]));
                if (pipe_mode[1] == 3'd0) disp[k] = disp[k] + 2 * $countones(act) - 10;
                else disp[k] = 0;
                if (disp[k] > max_disp) max_disp = disp[k];
                if (-disp[k] > max_disp) max_disp = -disp[k];
            end
        end
        pipe_exp[1]  = pipe_exp[0];
        pipe_mode[1] = pipe_mode[0];
        pipe_v[1]    = pipe_v[0];
        pipe_tag[1]  = pipe_tag[0];
        dut_if.mode = m;
        dut_if.data = d;
        dut_if.ctrl = c;
        dut_if.aux  = a;
        for (int k = 0; k < NUM_CH; k++) begin
            exp_all[10*k +: 10] = model_sym(m, k, d[8*k +: 8], c[2*k +: 2], a[4*k +: 4],
                                            tally_m[k], t_new);
            tally_m[k] = t_new;
        end
        pipe_exp[0]  = use_hand ? hand : exp_all;
        pipe_mode[0] = m;
        pipe_v[0]    = 1'b1;
        pipe_tag[0]  = tag;
    endtask

    // Holds reset for some negedges, checks the cleared outputs, then releases with CONTROL/00 applied.
    task automatic apply_reset(input int hold);
        rst_n       = 1'b0;
        dut_if.mode = 3'd1;
        dut_if.data = '0;
        dut_if.ctrl = '0;
        dut_if.aux  = '0;
        repeat (hold) @(negedge clk);
        check("reset tmds", 64'(dut_if.tmds), 64'(0));
        check("reset valid", 64'(dut_if.valid), 64'(0));
        rst_n       = 1'b1;
        steps_since = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            tally_m[k] = 0;
            disp[k]    = 0;
        end
        pipe_v[1]    = 1'b0;
        pipe_v[0]    = 1'b1;
        pipe_exp[0]  = {4{C00}};
        pipe_mode[0] = 3'd1;
        pipe_tag[0]  = "post-reset ctrl";
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{3'd1, 32'h0, 8'h00, 16'h0, {4{C00}}};
        vecs[1]  = '{3'd1, 32'h0, 8'b00_11_10_01, 16'h0, {C00, C11, C10, C01}};
        vecs[2]  = '{3'd6, 32'h0, 8'hFF, 16'h0, {4{C11}}};
        vecs[3]  = '{3'd2, 32'h0, 8'h00, 16'hFA50,
                     {10'b1011000011, 10'b0110011100, 10'b0100011110, 10'b1010011100}};
        vecs[4]  = '{3'd3, 32'h0, 8'h00, 16'h0, {GA, GA, GB, GA}};
        vecs[5]  = '{3'd4, 32'h0, 8'b01_00_00_10, 16'h0, {10'b1001110001, GB, GB, 10'b0101100011}};
        vecs[6]  = '{3'd0, 32'h101E_FF00, 8'h00, 16'h0,
                     {10'b0111110000, 10'b1001011111, 10'b1000000000, Z0}};
        vecs[7]  = '{3'd1, 32'h0, 8'h00, 16'h0, {4{C00}}};
        vecs[8]  = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z0}}};
        vecs[9]  = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z1}}};
        vecs[10] = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z0}}};
        vecs[11] = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z1}}};
        vecs[12] = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z0}}};
        vecs[13] = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z1}}};
        vecs[14] = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z0}}};
        vecs[15] = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z1}}};
        vecs[16] = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z0}}};
        vecs[17] = '{3'd0, 32'h0, 8'h00, 16'h0, {4{Z0}}};

        #1;
        apply_reset(2);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].mode, vecs[i].data, vecs[i].ctrl, vecs[i].aux, 1'b1, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            step((i % 2) ? 3'd1 : 3'd0, $urandom, 8'($urandom), 16'($urandom), 1'b0, '0, "alt1");
        end
        for (int i = 0; i < 30; i++) begin
            step((i % 3 == 2) ? 3'd1 : 3'd0, $urandom, 8'($urandom), 16'($urandom), 1'b0, '0, "alt3");
        end

        for (int i = 0; i < 10000; i++) begin
            step(3'd0, $urandom, 8'($urandom), 16'($urandom), 1'b0, '0, "rand video");
        end

        for (int i = 0; i < 5; i++) begin
            step(3'd0, $urandom, 8'($urandom), 16'($urandom), 1'b0, '0, "pre-abort");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset tmds", 64'(dut_if.tmds), 64'(0));
        check("async reset valid", 64'(dut_if.valid), 64'(0));
        apply_reset(2);
        for (int i = 0; i < 20; i++) begin
            step(3'd0, $urandom, 8'($urandom), 16'($urandom), 1'b0, '0, "post-abort");
        end

        for (int i = 0; i < 200; i++) begin
            step(3'($urandom_range(0, 7)), $urandom, 8'($urandom), 16'($urandom), 1'b0, '0, "mixed");
        end
        step(3'd1, '0, '0, '0, 1'b0, '0, "flush");
        step(3'd1, '0, '0, '0, 1'b0, '0, "flush");

        check("disparity bound", 64'(max_disp <= 8), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
